adaptive_threshold: RTL
=======================

Name: adaptive_threshold

Overview:
- Final stage of the adaptive thresholding pipeline, directly downstream of the 3x3 box filter.
- Raster-scans the source image memory and the box-filter mean memory in lockstep, compares each pixel against its local mean minus a constant offset, and writes a binary image (0/255) to the result memory.
- Started by the box filter's finished flag. Throughput is one pixel per clock.

Parameters:
- WIDTH_BITS, 8, bits of X coordinate
- HEIGHT_BITS, 8, bits of Y coordinate
- WIDTH, 2**WIDTH_BITS, image width in pixels
- HEIGHT, 2**HEIGHT_BITS, image height in pixels
- OFFSET, 2, constant C subtracted from the local mean (0..255)

Ports:
- clock  in  1  system clock, rising edge
- not_reset  in  1  asynchronous active-low reset
- iStart  in  1  level start request; tied to the box filter's finished
- oReadCol  out  WIDTH_BITS  X address shared by the image and mean memories
- oReadRow  out  HEIGHT_BITS  Y address shared by the image and mean memories
- iImageData  in  8  source pixel, valid one cycle after its address
- iMeanData  in  8  local mean, valid one cycle after its address
- oResultCol  out  WIDTH_BITS  result memory X address (registered)
- oResultRow  out  HEIGHT_BITS  result memory Y address (registered)
- oResultData  out  8  binary pixel, 0 or 255 (registered)
- oResultWren  out  1  result memory write enable, one pulse per pixel
- finished  out  1  high once every pixel has been written; held until reset

Behaviour:
- One clock domain. Reset is asynchronous and active-low: clock and not_reset.
- Reset values:
  - state = IDLE, pos = 0
  - oResultCol, oResultRow, oResultData = 0
  - oResultWren = 0, finished = 0
  - oReadCol/oReadRow are combinational from pos, so they read 0.
- pos is a (WIDTH_BITS+HEIGHT_BITS)-bit raster counter: low bits = column, high bits = row. oReadCol/oReadRow come directly from pos.
- Memories are synchronous with 1-cycle read latency. Data for the address presented in cycle k is on iImageData/iMeanData in cycle k+1.
- FSM states:
  - IDLE: pos held at 0, no writes. iStart=1 sampled at an edge moves to RUN.
  - RUN: address pos is presented each cycle and pos increments by 1 per clock. At pos == WIDTH*HEIGHT-1, pos is held and the FSM moves to DRAIN.
  - DRAIN: one cycle to capture the last pixel's data, then move to FLUSH.
  - FLUSH: last write pulse is visible. Move to DONE and set finished.
  - DONE: finished = 1. iStart is ignored and no writes occur until reset.
- A valid pipeline bit tags each issued address. Pipeline stage 1 registers the outputs and the delayed address, so the result for address k appears on oResultCol/Row/Data with oResultWren=1 in cycle k+2 after RUN entry.
- oResultWren is high for exactly WIDTH*HEIGHT consecutive cycles, with no gaps.
- finished rises the cycle after the final oResultWren pulse. Total time from start to finished is WIDTH*HEIGHT+2 cycles after RUN entry.
- Arithmetic:
  - threshold = {2'b0,iMeanData} - OFFSET, computed as 10-bit signed. It is never truncated, so a negative threshold makes every pixel foreground.
  - Foreground when {2'b0,iImageData} > threshold (strict).
  - Foreground writes 255 and background writes 0.
- oResultData holds its last value when oResultWren=0.
- Reset asserted mid-operation: all outputs return to reset values immediately, no further writes occur, and the next run requires a fresh iStart.
- If iStart is already high when reset deasserts, RUN starts at the first clock edge.

Optional Feature:
- Macro ADAPTIVE_THRESHOLD_INVERT_EN.
- Defined: polarity is inverted. Foreground (written as 255) is {2'b0,iImageData} <= threshold, i.e. dark text on a light background becomes white.
- Undefined: the rule in Behaviour applies.
- Timing and all other behaviour are identical in both cases.

Test Plan:
- 4x4 (WIDTH_BITS=HEIGHT_BITS=2), OFFSET=2. Image all 100, mean all 100 → 16 writes with data 255 (100 > 98). finished is high 18 cycles after RUN entry.
- Image 97, mean 100, OFFSET=2 → data 0 (97 <= 98). Image 99 → 255. Image 98 → 0 (strict compare).
- Mean 1, image 0, OFFSET=2 → threshold -1 → data 255 (no wrap to 255). Mean 255, image 255 → 255.
- iStart held low for 10 cycles → oResultWren never asserts and finished=0. iStart pulsed 1 cycle → a full run completes.
- Write sequence check: oResultCol/Row step (0,0),(1,0)…(3,3) with oResultWren continuous for 16 cycles. After finished=1, toggling iStart produces no writes.
- Reset asserted after the 5th write → outputs zero immediately. Restart writes all 16 pixels from (0,0). With ADAPTIVE_THRESHOLD_INVERT_EN defined, the first scenario yields all 0.

Source files
------------

// File: rtl/adaptive_threshold.sv
// Adaptive threshold stage: raster-scans image and local-mean memories, writes 0/255 binary pixels.
// Optional macro ADAPTIVE_THRESHOLD_INVERT_EN inverts the foreground polarity (dark pixels become 255).
module adaptive_threshold #(
    parameter int WIDTH_BITS  = 8,
    parameter int HEIGHT_BITS = 8,
    parameter int WIDTH       = 2**WIDTH_BITS,
    parameter int HEIGHT      = 2**HEIGHT_BITS,
    parameter int OFFSET      = 2
) (
    input  logic                   clock,
    input  logic                   not_reset,
    input  logic                   iStart,
    output logic [WIDTH_BITS-1:0]  oReadCol,
    output logic [HEIGHT_BITS-1:0] oReadRow,
    input  logic [7:0]             iImageData,
    input  logic [7:0]             iMeanData,
    output logic [WIDTH_BITS-1:0]  oResultCol,
    output logic [HEIGHT_BITS-1:0] oResultRow,
    output logic [7:0]             oResultData,
    output logic                   oResultWren,
    output logic                   finished
);

    localparam int PW = WIDTH_BITS + HEIGHT_BITS;
    localparam logic [PW-1:0] LAST_POS = PW'(WIDTH * HEIGHT - 1);
    localparam logic [PW-1:0] POS_ZERO = PW'(0);
    localparam logic [PW-1:0] POS_ONE  = PW'(1);
    localparam logic signed [9:0] OFFSET_S = 10'(OFFSET);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RUN   = 3'd1,
        DRAIN = 3'd2,
        FLUSH = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t          state_r;
    state_t          next_state_s;
    logic [PW-1:0]   pos_r;
    logic [PW-1:0]   pos_next_s;
    logic            issue_valid_r;
    logic [PW-1:0]   issue_pos_r;
    logic [7:0]      pixel_s;

    // Threshold is kept 10-bit signed so a mean below OFFSET gives a negative threshold, never a wrap.
    function automatic logic [7:0] binarize(input logic [7:0] pixel, input logic [7:0] mean);
        logic signed [9:0] thr;
        logic signed [9:0] pix;
        logic              fg;
        thr = $signed({2'b00, mean}) - OFFSET_S;
        pix = $signed({2'b00, pixel});
`ifdef ADAPTIVE_THRESHOLD_INVERT_EN
        fg = (pix <= thr);
`else
        fg = (pix > thr);
`endif
        return fg ? 8'hFF : 8'h00;
    endfunction

    assign oReadCol = pos_r[WIDTH_BITS-1:0];
    assign oReadRow = pos_r[PW-1:WIDTH_BITS];
    assign pixel_s  = binarize(iImageData, iMeanData);

    // State and raster-position registers.
    always_ff @(posedge clock or negedge not_reset) begin
        if (!not_reset) begin
            state_r <= IDLE;
            pos_r   <= POS_ZERO;
        end else begin
            state_r <= next_state_s;
            pos_r   <= pos_next_s;
        end
    end

    // Next-state and next-position logic.
    always_comb begin
        next_state_s = state_r;
        pos_next_s   = pos_r;
        case (state_r)
            IDLE: begin
                pos_next_s = POS_ZERO;
                if (iStart) begin
                    next_state_s = RUN;
                end else begin
                    next_state_s = IDLE;
                end
            end
            RUN: begin
                if (pos_r == LAST_POS) begin
                    next_state_s = DRAIN;
                    pos_next_s   = pos_r;
                end else begin
                    next_state_s = RUN;
                    pos_next_s   = pos_r + POS_ONE;
                end
            end
            DRAIN:   next_state_s = FLUSH;
            FLUSH:   next_state_s = DONE;
            DONE:    next_state_s = DONE;
            default: begin
                next_state_s = IDLE;
                pos_next_s   = POS_ZERO;
            end
        endcase
    end

    // Tag each issued address so its data (one cycle later) can be matched with it.
    always_ff @(posedge clock or negedge not_reset) begin
        if (!not_reset) begin
            issue_valid_r <= 1'b0;
            issue_pos_r   <= POS_ZERO;
        end else begin
            issue_valid_r <= (state_r == RUN);
            issue_pos_r   <= pos_r;
        end
    end

    // Result write port; address and data hold their last values between writes.
    always_ff @(posedge clock or negedge not_reset) begin
        if (!not_reset) begin
            oResultCol  <= {WIDTH_BITS{1'b0}};
            oResultRow  <= {HEIGHT_BITS{1'b0}};
            oResultData <= 8'h00;
            oResultWren <= 1'b0;
        end else begin
            oResultWren <= issue_valid_r;
            if (issue_valid_r) begin
                oResultCol  <= issue_pos_r[WIDTH_BITS-1:0];
                oResultRow  <= issue_pos_r[PW-1:WIDTH_BITS];
                oResultData <= pixel_s;
            end
        end
    end

    // Completion flag, sticky until reset.
    always_ff @(posedge clock or negedge not_reset) begin
        if (!not_reset) begin
            finished <= 1'b0;
        end else begin
            finished <= (next_state_s == DONE);
        end
    end

endmodule
